// File: rtl/div_seq.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) that borrows the core's shared ALU
// through a request/grant port, one ALU operation per granted cycle.

package div_seq_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_SLL  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_SLT  = 4'd8,
        ALU_OP_SLTU = 4'd9
    } alu_ctrl_t;
endpackage

module div_seq
    import div_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  word_t           req_a,
    input  word_t           req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output word_t           resp_data,
    output logic            alu_req,
    input  logic            alu_gnt,
    output alu_ctrl_t       alu_ctrl,
    output word_t [1:0]     alu_in,
    input  word_t           alu_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEG_A  = 3'd1,
        NEG_B  = 3'd2,
        DIVIDE = 3'd3,
        FIX    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam word_t INT_MIN = 32'h8000_0000;
    localparam word_t ALL_ONE = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    word_t       r_q, r_d;
    word_t       q_q, q_d;
    word_t       d_q, d_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    word_t       res_q, res_d;

    logic [32:0] r_sh;
    logic        ge;
    word_t       r_step;
    word_t       q_step;
    logic        req_signed;
    logic        pre_ge;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= 32'd0;
            q_q       <= 32'd0;
            d_q       <= 32'd0;
            cnt_q     <= 6'd0;
            op_q      <= 2'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
        end
    end

    // Next-state, datapath update and shared-ALU drive.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        q_d       = q_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        alu_req   = 1'b0;
        alu_ctrl  = ALU_OP_ADD;
        alu_in[0] = 32'd0;
        alu_in[1] = 32'd0;
        pre_ge    = 1'b0;

        req_signed = ~req_op[0];
        r_sh   = {r_q, q_q[31]};
        ge     = r_sh[32] | (r_sh[31:0] >= d_q);
        r_step = ge ? alu_out : r_sh[31:0];
        q_step = {q_q[30:0], ge};

        // The first restoring step has r=0, so r_sh is just the dividend MSB and the
        // compare reduces to "divisor == 1"; it is folded into the edge that sets up d.
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    q_d       = req_a;
                    d_d       = req_b;
                    r_d       = 32'd0;
                    cnt_d     = 6'd0;
                    neg_quo_d = req_signed & (req_a[31] ^ req_b[31]);
                    neg_rem_d = req_signed & req_a[31];
                    if (req_b == 32'd0) begin
                        res_d   = req_op[1] ? req_a : ALL_ONE;
                        state_d = DONE;
                    end else if (req_signed && (req_a == INT_MIN) && (req_b == ALL_ONE)) begin
                        res_d   = req_op[1] ? 32'd0 : INT_MIN;
                        state_d = DONE;
                    end else if (req_signed) begin
                        state_d = NEG_A;
                    end else begin
                        pre_ge  = req_a[31] & (req_b == 32'd1);
                        r_d     = {31'd0, req_a[31] & ~pre_ge};
                        q_d     = {req_a[30:0], pre_ge};
                        cnt_d   = 6'd1;
                        state_d = DIVIDE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            NEG_A: begin
                alu_req   = 1'b1;
                alu_ctrl  = q_q[31] ? ALU_OP_SUB : ALU_OP_ADD;
                alu_in[1] = q_q;
                if (alu_gnt) begin
                    q_d     = alu_out;
                    state_d = NEG_B;
                end else begin
                    state_d = NEG_A;
                end
            end
            NEG_B: begin
                alu_req   = 1'b1;
                alu_ctrl  = d_q[31] ? ALU_OP_SUB : ALU_OP_ADD;
                alu_in[1] = d_q;
                if (alu_gnt) begin
                    pre_ge  = q_q[31] & (alu_out == 32'd1);
                    d_d     = alu_out;
                    r_d     = {31'd0, q_q[31] & ~pre_ge};
                    q_d     = {q_q[30:0], pre_ge};
                    cnt_d   = 6'd1;
                    state_d = DIVIDE;
                end else begin
                    state_d = NEG_B;
                end
            end
            DIVIDE: begin
                alu_req   = 1'b1;
                alu_ctrl  = ALU_OP_SUB;
                alu_in[0] = r_sh[31:0];
                alu_in[1] = d_q;
                if (alu_gnt) begin
                    r_d   = r_step;
                    q_d   = q_step;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        if (!op_q[0]) begin
                            state_d = FIX;
                        end else begin
                            res_d   = op_q[1] ? r_step : q_step;
                            state_d = DONE;
                        end
                    end else begin
                        state_d = DIVIDE;
                    end
                end else begin
                    state_d = DIVIDE;
                end
            end
            FIX: begin
                alu_req   = 1'b1;
                alu_in[1] = op_q[1] ? r_q : q_q;
                alu_ctrl  = (op_q[1] ? neg_rem_q : neg_quo_q) ? ALU_OP_SUB : ALU_OP_ADD;
                if (alu_gnt) begin
                    res_d   = alu_out;
                    state_d = DONE;
                end else begin
                    state_d = FIX;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_data  = res_q;

endmodule
